prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 119 +++++++++++
 tb/tb_prog_clock_divider.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: period and high-phase length are configurable at run time.
// A config loaded while running takes effect only on a period boundary, so no period is ever cut short or stretched.
module prog_clock_divider #(
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned DEFAULT_DIV  = 125000000,
  parameter int unsigned DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt, high_act, high_act_nxt;
  logic [CNT_W-1:0] div_pend, div_pend_nxt, high_pend, high_pend_nxt;
  logic             pending_nxt, clk_out_nxt, tick_nxt, cfg_err_nxt;
  logic             running, wrap, load_ok;

  assign load_ok = load && (div_in >= TWO) && (high_in <= div_in);
  assign running = (state == RUN) && en;
  assign wrap    = (cnt == div_act - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = en ? RUN : IDLE;
  end

  // While running, loads go to the pending slot; otherwise they update the active config directly.
  always_comb begin
    cnt_nxt       = cnt;
    div_act_nxt   = div_act;
    high_act_nxt  = high_act;
    div_pend_nxt  = div_pend;
    high_pend_nxt = high_pend;
    pending_nxt   = cfg_pending;
    if (running) begin
      if (wrap) begin
        cnt_nxt = '0;
        if (cfg_pending) begin
          div_act_nxt  = div_pend;
          high_act_nxt = high_pend;
          pending_nxt  = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + ONE;
      end
      if (load_ok) begin
        div_pend_nxt  = div_in;
        high_pend_nxt = high_in;
        pending_nxt   = 1'b1;
      end
    end else begin
      cnt_nxt = '0;
      if (cfg_pending) begin
        div_act_nxt  = div_pend;
        high_act_nxt = high_pend;
        pending_nxt  = 1'b0;
      end
      if (load_ok) begin
        div_act_nxt  = div_in;
        high_act_nxt = high_in;
      end
    end
  end

  always_comb begin
    clk_out_nxt = 1'b0;
    tick_nxt    = 1'b0;
    if (en) begin
      tick_nxt    = (cnt_nxt == '0);
      clk_out_nxt = (cnt_nxt < high_act_nxt);
    end
    cfg_err_nxt = load && !load_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      div_act     <= DIV_RST;
      high_act    <= HIGH_RST;
      div_pend    <= DIV_RST;
      high_pend   <= HIGH_RST;
      cfg_pending <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      div_act     <= div_act_nxt;
      high_act    <= high_act_nxt;
      div_pend    <= div_pend_nxt;
      high_pend   <= high_pend_nxt;
      cfg_pending <= pending_nxt;
      clk_out     <= clk_out_nxt;
      tick        <= tick_nxt;
      cfg_err     <= cfg_err_nxt;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider with a small period-position reference model.
// Directed scenarios use explicit waveform arithmetic; the random phase compares against the model.
module tb_prog_clock_divider;

  localparam int CNT_W    = 8;
  localparam int DEF_DIV  = 10;
  localparam int DEF_HIGH = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic [CNT_W-1:0] high_in = '0;
  logic             clk_out, tick, cfg_pending, cfg_err;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: position within the current output period plus active/pending config.
  bit m_run, m_pend, m_clk, m_tick, m_err;
  int m_phase, m_div, m_high, p_div, p_high;

  prog_clock_divider #(
    .CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV), .DEFAULT_HIGH(DEF_HIGH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .div_in(div_in), .high_in(high_in),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0; m_phase = 0;
    m_div = DEF_DIV; m_high = DEF_HIGH; p_div = DEF_DIV; p_high = DEF_HIGH;
  endtask

  task automatic model_edge(input bit e, input bit l, input int d, input int h);
    bit ok;
    ok = l && (d >= 2) && (h <= d);
    m_err = l && !ok;
    if (!e) begin
      if (m_pend) begin m_div = p_div; m_high = p_high; m_pend = 0; end
      if (ok) begin m_div = d; m_high = h; end
      m_run = 0; m_phase = 0;
    end else if (!m_run) begin
      if (ok) begin m_div = d; m_high = h; end
      m_run = 1; m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % m_div;
      if (m_phase == 0 && m_pend) begin m_div = p_div; m_high = p_high; m_pend = 0; end
      if (ok) begin p_div = d; p_high = h; m_pend = 1; end
    end
    m_clk  = e && (m_phase < m_high);
    m_tick = e && (m_phase == 0);
  endtask

  task automatic step(input bit e, input bit l, input int d, input int h);
    logic [31:0] dv, hv;
    dv = d; hv = h;
    en = e; load = l; div_in = dv[CNT_W-1:0]; high_in = hv[CNT_W-1:0];
    @(posedge clk);
    model_edge(e, l, d, h);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    assert_cnt++;
    if ({clk_out, tick, cfg_pending, cfg_err} !== 4'b0000) begin
      fail_cnt++;
      $display("[TB] FAIL reset_async: outputs=%b expected 0000", {clk_out, tick, cfg_pending, cfg_err});
    end
    @(posedge clk); #1;
    assert_cnt++;
    if ({clk_out, tick, cfg_pending, cfg_err} !== 4'b0000) begin
      fail_cnt++;
      $display("[TB] FAIL reset_held: outputs=%b expected 0000", {clk_out, tick, cfg_pending, cfg_err});
    end
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_default_waveform();
    for (int i = 0; i < 25; i++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== ((i % 10) < 5) || tick !== ((i % 10) == 0) || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL default_wave cyc %0d: clk_out=%b tick=%b pend=%b expected %b %b 0",
                 i, clk_out, tick, cfg_pending, (i % 10) < 5, (i % 10) == 0);
      end
    end
  endtask

  task automatic test_pending_load();
    for (int n = 0; n < 20 && m_phase != 3; n++) step(1, 0, 0, 0);
    step(1, 1, 4, 1);
    assert_cnt++;
    if (cfg_pending !== 1'b1 || clk_out !== 1'b1 || tick !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL pend_set: pend=%b clk_out=%b tick=%b expected 1 1 0", cfg_pending, clk_out, tick);
    end
    for (int j = 5; j < 10; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_pending !== 1'b1) begin
        fail_cnt++;
        $display("[TB] FAIL old_period phase %0d: clk_out=%b tick=%b pend=%b expected 0 0 1",
                 j, clk_out, tick, cfg_pending);
      end
    end
    for (int j = 0; j < 12; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== ((j % 4) == 0) || tick !== ((j % 4) == 0) || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL new_period cyc %0d: clk_out=%b tick=%b pend=%b expected %b %b 0",
                 j, clk_out, tick, cfg_pending, (j % 4) == 0, (j % 4) == 0);
      end
    end
  endtask

  task automatic test_bad_load();
    step(1, 1, 1, 0);
    assert_cnt++;
    if (cfg_err !== 1'b1 || cfg_pending !== 1'b0 || clk_out !== m_clk || tick !== m_tick) begin
      fail_cnt++;
      $display("[TB] FAIL err_div1: err=%b pend=%b clk_out=%b tick=%b expected 1 0 %b %b",
               cfg_err, cfg_pending, clk_out, tick, m_clk, m_tick);
    end
    step(1, 0, 0, 0);
    assert_cnt++;
    if (cfg_err !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL err_pulse_len: err=%b expected 0", cfg_err);
    end
    step(1, 1, 6, 7);
    assert_cnt++;
    if (cfg_err !== 1'b1 || cfg_pending !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL err_high_gt_div: err=%b pend=%b expected 1 0", cfg_err, cfg_pending);
    end
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== ((j + m_phase - j) % 4 == 0) || clk_out !== m_clk || tick !== m_tick ||
          cfg_err !== 1'b0 || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL after_err cyc %0d: clk_out=%b tick=%b err=%b pend=%b expected %b %b 0 0",
                 j, clk_out, tick, cfg_err, cfg_pending, m_clk, m_tick);
      end
    end
  endtask

  task automatic test_edge_high();
    int ticks;
    step(1, 1, 4, 0);
    assert_cnt++;
    if (cfg_pending !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL high0_pend: pend=%b expected 1", cfg_pending);
    end
    repeat (5) step(1, 0, 0, 0);
    ticks = 0;
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 0);
      ticks += int'(tick);
      assert_cnt++;
      if (clk_out !== 1'b0 || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL high0_const cyc %0d: clk_out=%b pend=%b expected 0 0", j, clk_out, cfg_pending);
      end
    end
    assert_cnt++;
    if (ticks != 2) begin
      fail_cnt++;
      $display("[TB] FAIL high0_ticks: got %0d ticks expected 2", ticks);
    end
    step(1, 1, 6, 6);
    repeat (5) step(1, 0, 0, 0);
    ticks = 0;
    for (int j = 0; j < 12; j++) begin
      step(1, 0, 0, 0);
      ticks += int'(tick);
      assert_cnt++;
      if (clk_out !== 1'b1 || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL highfull_const cyc %0d: clk_out=%b pend=%b expected 1 0", j, clk_out, cfg_pending);
      end
    end
    assert_cnt++;
    if (ticks != 2) begin
      fail_cnt++;
      $display("[TB] FAIL highfull_ticks: got %0d ticks expected 2", ticks);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 5, 2);
    for (int n = 0; n < 12 && m_phase != m_div - 1; n++) step(1, 0, 0, 0);
    step(1, 1, 8, 3);
    assert_cnt++;
    if (cfg_pending !== 1'b1 || tick !== 1'b1 || clk_out !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL b2b_boundary: pend=%b tick=%b clk_out=%b expected 1 1 1", cfg_pending, tick, clk_out);
    end
    for (int j = 1; j < 5; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== (j < 2) || tick !== 1'b0 || cfg_pending !== 1'b1) begin
        fail_cnt++;
        $display("[TB] FAIL b2b_first phase %0d: clk_out=%b tick=%b pend=%b expected %b 0 1",
                 j, clk_out, tick, cfg_pending, j < 2);
      end
    end
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== (j < 3) || tick !== (j == 0) || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL b2b_second phase %0d: clk_out=%b tick=%b pend=%b expected %b %b 0",
                 j, clk_out, tick, cfg_pending, j < 3, j == 0);
      end
    end
  endtask

  task automatic test_idle();
    for (int n = 0; n < 16 && m_phase != 2; n++) step(1, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, j == 2, 6, 2);
      assert_cnt++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_pending !== 1'b0 || cfg_err !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL idle cyc %0d: clk_out=%b tick=%b pend=%b err=%b expected 0 0 0 0",
                 j, clk_out, tick, cfg_pending, cfg_err);
      end
    end
    for (int j = 0; j < 12; j++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== ((j % 6) < 2) || tick !== ((j % 6) == 0) || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL reenable cyc %0d: clk_out=%b tick=%b pend=%b expected %b %b 0",
                 j, clk_out, tick, cfg_pending, (j % 6) < 2, (j % 6) == 0);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 3, 1);
    assert_cnt++;
    if (cfg_pending !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL rst_pend_setup: pend=%b expected 1", cfg_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    assert_cnt++;
    if ({clk_out, tick, cfg_pending, cfg_err} !== 4'b0000) begin
      fail_cnt++;
      $display("[TB] FAIL rst_mid: outputs=%b expected 0000", {clk_out, tick, cfg_pending, cfg_err});
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      assert_cnt++;
      if (clk_out !== ((i % 10) < 5) || tick !== ((i % 10) == 0) || cfg_pending !== 1'b0) begin
        fail_cnt++;
        $display("[TB] FAIL post_rst cyc %0d: clk_out=%b tick=%b pend=%b expected %b %b 0",
                 i, clk_out, tick, cfg_pending, (i % 10) < 5, (i % 10) == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit e, l;
      int d, h;
      e = m_run ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 3) != 0);
      if (m_pend) e = 1'b1;
      l = (e == m_run) && ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 12);
      h = $urandom_range(0, 13);
      step(e, l, d, h);
      assert_cnt++;
      if (clk_out !== m_clk || tick !== m_tick || cfg_pending !== m_pend || cfg_err !== m_err) begin
        fail_cnt++;
        $display("[TB] FAIL random cyc %0d: clk_out=%b tick=%b pend=%b err=%b expected %b %b %b %b",
                 c, clk_out, tick, cfg_pending, cfg_err, m_clk, m_tick, m_pend, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_waveform();
    test_pending_load();
    test_bad_load();
    test_edge_high();
    test_back_to_back();
    test_idle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
